// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolution: evaluates the condition from comparator flags,
// detects mispredicts, issues a registered redirect and holds a flush window.
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  input  logic             i_stall,
  input  logic             i_is_br,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  input  logic             i_pred_taken,
  input  logic [31:0]      i_pc,
  input  logic [31:0]      i_target,
  output logic             o_br_un,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_flush,
  output logic             o_illegal_br,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       taken;
  logic       bad_funct3;
  logic       resolve;
  logic       mispredict;
  logic [31:0] redirect_pc_d;

  always_comb begin
    case (i_funct3)
      3'b110, 3'b111: o_br_un = 1'b0;
      default:        o_br_un = 1'b1;
    endcase
  end

  // Jumps dominate a simultaneously flagged conditional branch.
  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    if (i_is_jalr || i_is_jal) begin
      taken = 1'b1;
    end else begin
      case (i_funct3)
        3'b000:         taken = i_br_equal;
        3'b001:         taken = ~i_br_equal;
        3'b100, 3'b110: taken = i_br_less;
        3'b101, 3'b111: taken = ~i_br_less;
        default: begin
          taken      = 1'b0;
          bad_funct3 = i_is_br;
        end
      endcase
    end
  end

  assign resolve       = i_ex_valid & ~i_stall & (i_is_br | i_is_jal | i_is_jalr)
                       & (state_q == IDLE);
  assign mispredict    = resolve & (i_is_jalr | (taken != i_pred_taken));
  assign redirect_pc_d = taken ? i_target : (i_pc + 32'd4);
  assign o_flush       = (state_q == FLUSH);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_illegal_br     <= 1'b0;
    end else begin
      o_redirect_valid <= mispredict;
      o_illegal_br     <= resolve & bad_funct3;
      if (mispredict) begin
        o_redirect_pc <= redirect_pc_d;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (resolve && (o_br_cnt != '1)) begin
        o_br_cnt <= o_br_cnt + CNT_W'(1);
      end
      if (mispredict && (o_mispred_cnt != '1)) begin
        o_mispred_cnt <= o_mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule
